// File: rtl/neuron_mac_sequencer_if.sv
// Stream, weight-load and result bus for one time-multiplexed neuron.
// The master side is the producer/consumer; the slave side is the sequencer.
interface neuron_mac_sequencer_if #(
    parameter int NUM_INPUTS = 4
);
    localparam int AW    = $clog2(NUM_INPUTS);
    localparam int ACC_W = 16 + $clog2(NUM_INPUTS);

    logic             w_we;
    logic [AW-1:0]    w_addr;
    logic [7:0]       w_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [ACC_W-1:0] out_sum;
    logic             busy;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sum, busy
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sum, busy
    );
endinterface

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron controller: one shared 8x8 MAC accumulates a streamed input vector
// against stored weights, then emits a shifted, saturated 8-bit activation.
module neuron_mac_sequencer #(
    parameter int NUM_INPUTS = 4,
    parameter int SHIFT      = 0
) (
    input  logic                clk,
    input  logic                rst,
    neuron_mac_sequencer_if.slave bus
);
    localparam int AW    = $clog2(NUM_INPUTS);
    localparam int ACC_W = 16 + $clog2(NUM_INPUTS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t           state_r;
    logic [AW-1:0]    idx_r;
    logic [ACC_W-1:0] acc_r;
    logic [7:0]       weight_r [NUM_INPUTS];
    logic             in_ready_r;
    logic             out_valid_r;
    logic [7:0]       out_data_r;
    logic [ACC_W-1:0] out_sum_r;
    logic             busy_r;

    logic             handshake_s;
    logic [15:0]      product_s;
    logic [ACC_W-1:0] base_s;
    logic [ACC_W-1:0] sum_s;

    function automatic logic [7:0] saturate(input logic [ACC_W-1:0] value);
        if (value > ACC_W'(255)) begin
            return 8'hFF;
        end else begin
            return value[7:0];
        end
    endfunction

    // MAC datapath; IDLE starts a fresh sum so no stale accumulator leaks in.
    always_comb begin
        handshake_s = bus.in_valid & in_ready_r;
        product_s   = 16'(bus.in_data) * 16'(weight_r[idx_r]);
        if (state_r == IDLE) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        sum_s = base_s + ACC_W'(product_s);
    end

    // Sequencer FSM with weight storage and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            acc_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'd0;
            out_sum_r   <= '0;
            busy_r      <= 1'b0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                weight_r[i] <= 8'd0;
            end
        end else begin
            // The MAC reads the pre-write weight when a write coincides with element 0.
            if (bus.w_we && (state_r == IDLE)) begin
                weight_r[bus.w_addr] <= bus.w_data;
            end
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        acc_r   <= sum_s;
                        idx_r   <= AW'(1);
                        busy_r  <= 1'b1;
                        state_r <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (handshake_s) begin
                        acc_r <= sum_s;
                        if (idx_r == LAST_IDX) begin
                            out_sum_r   <= sum_s;
                            out_data_r  <= saturate(sum_s >> SHIFT);
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            idx_r       <= '0;
                            state_r     <= OUT;
                        end else begin
                            idx_r <= idx_r + AW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    idx_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sum   = out_sum_r;
    assign bus.busy      = busy_r;
endmodule
